regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//   Parametrised multi-read-port register file for the pipelined core, with an
//   integrated pending-write scoreboard.
//   - Read path: combinational. Optional write-to-read bypass in the same cycle.
//   - Write path: synchronous.
//   - Scoreboard: one pending bit per register. Set when a producer issues,
//     cleared at writeback. Drives the decode-stage Stall output.
// PARAMETERS
//   DATA_W    32  register width in bits
//   NUM_REGS  32  number of architectural registers (>=2)
//   ADDR_W    5   register index width; must equal $clog2(NUM_REGS)
//   NUM_RD    2   number of read ports (1..4)
//   ZERO_REG  1   1: register 0 reads 0, ignores writes, is never pending
//   BYPASS    1   1: same-cycle writeback data forwarded to reads
// PORTS
//   Clk       in   1               clock, all state updates on rising edge
//   Rst_n     in   1               async active-low reset
//   RegWrite  in   1               writeback enable
//   Rd        in   ADDR_W          writeback register index
//   WriteData in   DATA_W          writeback data
//   RdAddr    in   NUM_RD*ADDR_W   read indices; port k = bits [k*ADDR_W +: ADDR_W]
//   RdData    out  NUM_RD*DATA_W   read data; port k = bits [k*DATA_W +: DATA_W]
//   RdPend    out  NUM_RD          port k reads a register awaiting writeback
//   Issue     in   1               decode issues an instruction that writes IssueRd
//   IssueRd   in   ADDR_W          destination of the issuing instruction
//   Stall     out  1               decode must hold; an Issue in the same cycle is ignored
// BEHAVIOUR
//   Reset (Rst_n=0, asynchronous):
//     - All registers = 0 and all pending bits = 0 immediately.
//     - Outputs then follow from that state: RdData=0, RdPend=0, Stall=0.
//   Write (rising Clk, RegWrite=1):
//     - regs[Rd] <= WriteData and pend[Rd] <= 0.
//     - Ignored when ZERO_REG=1 and Rd=0.
//     - Rd >= NUM_REGS: write discarded.
//   Read (combinational, zero latency):
//     - RdData[k] = regs[RdAddr[k]].
//     - Returns 0 when ZERO_REG=1 and the index is 0, or when the index >= NUM_REGS.
//     - Bypass (BYPASS=1, RegWrite=1, Rd=RdAddr[k], Rd a writable index):
//       RdData[k] = WriteData and RdPend[k] = 0.
//     - Otherwise RdPend[k] = pend[RdAddr[k]].
//   Scoreboard set (rising Clk):
//     - Issue=1 and Stall=0 -> pend[IssueRd] <= 1.
//     - Skipped when ZERO_REG=1 and IssueRd=0.
//   Simultaneous write and issue:
//     - Same register: set wins; pend stays 1 for the new producer.
//     - Different registers: both take effect.
//   Stall (combinational) = OR of:
//     - any RdPend[k] (RAW hazard);
//     - Issue=1 and pend[IssueRd]=1 and not (RegWrite=1 and Rd=IssueRd)
//       (WAW hazard; a WAW clearing this cycle does not stall).
//   Reset mid-operation: all in-flight pending bits are discarded.
//   Stall does not depend on Stall, so there are no combinational loops.
//   Multiple read ports addressing the same register return identical data.
// TESTING
//   1. Reset: assert Rst_n=0 mid-run after writes.
//      -> all RdData=0, RdPend=0, Stall=0 without waiting for a clock edge.
//   2. Basic write/read: write 32'hDEADBEEF to r5, then read r5 on both ports the next cycle.
//      -> both ports return 32'hDEADBEEF, RdPend=2'b00.
//   3. Zero register: write 32'h1234 to r0, then read r0.
//      -> returns 0. Issue to r0 -> never pending, Stall=0.
//   4. Bypass: RegWrite=1, Rd=7, WriteData=32'hA5A5A5A5, RdAddr port1=7, same cycle.
//      -> RdData port1 = 32'hA5A5A5A5, RdPend[1]=0.
//   5. RAW then WAW:
//      - Issue r3 -> next cycle reading r3 gives RdPend=1, Stall=1; Issue r3 again
//        gives Stall=1 and the issue is ignored.
//      - Write r3 = 32'h55 -> that cycle Stall=0 and data is bypassed.
//      - Next cycle pend[r3]=0.
//   6. Simultaneous set and clear: pend[r9]=1; same edge RegWrite Rd=9 and Issue IssueRd=9
//      (Stall=0).
//      -> after the edge regs[9]=WriteData and pend[9]=1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
// Reads are combinational with optional same-cycle writeback bypass; Stall covers RAW and WAW.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        Rd,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic [NUM_RD*ADDR_W-1:0] RdAddr,
    output logic [NUM_RD*DATA_W-1:0] RdData,
    output logic [NUM_RD-1:0]        RdPend,
    input  logic                     Issue,
    input  logic [ADDR_W-1:0]        IssueRd,
    output logic                     Stall
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pend;

    // Index names a real register that may be written or marked pending.
    function automatic logic writable(input logic [ADDR_W-1:0] idx);
        return (32'(idx) < NUM_REGS) && !((ZERO_REG != 0) && (idx == '0));
    endfunction

    logic wr_en;
    logic issue_ok;
    logic waw;

    assign wr_en    = RegWrite && writable(Rd);
    assign issue_ok = writable(IssueRd);

    always_comb begin
        RdData = '0;
        RdPend = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            logic [ADDR_W-1:0] addr;
            addr = RdAddr[k*ADDR_W +: ADDR_W];
            if ((BYPASS != 0) && wr_en && (Rd == addr)) begin
                RdData[k*DATA_W +: DATA_W] = WriteData;
                RdPend[k]                  = 1'b0;
            end else if (writable(addr)) begin
                RdData[k*DATA_W +: DATA_W] = regs[addr];
                RdPend[k]                  = pend[addr];
            end
        end
    end

    // A writeback to the issuing destination this cycle resolves the WAW hazard.
    always_comb begin
        waw = 1'b0;
        if (Issue && issue_ok) begin
            waw = pend[IssueRd] && !(wr_en && (Rd == IssueRd));
        end
    end

    assign Stall = (|RdPend) || waw;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pend <= '0;
        end else begin
            if (wr_en) begin
                regs[Rd] <= WriteData;
                pend[Rd] <= 1'b0;
            end
            // Placed after the clear so a new producer on the same register wins.
            if (Issue && !Stall && issue_ok) begin
                pend[IssueRd] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, read/write, zero register,
// bypass, RAW/WAW stalls and simultaneous set/clear of a pending bit.
module tb_regfile_scoreboard;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NUM_RD = 2;

    logic                     Clk;
    logic                     Rst_n;
    logic                     RegWrite;
    logic [ADDR_W-1:0]        Rd;
    logic [DATA_W-1:0]        WriteData;
    logic [NUM_RD*ADDR_W-1:0] RdAddr;
    logic [NUM_RD*DATA_W-1:0] RdData;
    logic [NUM_RD-1:0]        RdPend;
    logic                     Issue;
    logic [ADDR_W-1:0]        IssueRd;
    logic                     Stall;

    int checks   = 0;
    int failures = 0;

    regfile_scoreboard #(
        .DATA_W  (DATA_W),
        .NUM_REGS(32),
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1),
        .BYPASS  (1)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .RegWrite (RegWrite),
        .Rd       (Rd),
        .WriteData(WriteData),
        .RdAddr   (RdAddr),
        .RdData   (RdData),
        .RdPend   (RdPend),
        .Issue    (Issue),
        .IssueRd  (IssueRd),
        .Stall    (Stall)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [NUM_RD*ADDR_W-1:0] addrs(input logic [ADDR_W-1:0] p1,
                                                      input logic [ADDR_W-1:0] p0);
        return {p1, p0};
    endfunction

    initial begin
        Rst_n = 1'b0; RegWrite = 1'b0; Rd = '0; WriteData = '0;
        RdAddr = '0; Issue = 1'b0; IssueRd = '0;
        #3;
        chk("reset_data", 64'(RdData), 64'h0);
        chk("reset_pend", 64'(RdPend), 64'h0);
        chk("reset_stall", 64'(Stall), 64'h0);
        Rst_n = 1'b1;
        step();

        // Basic write then read on both ports
        RegWrite = 1'b1; Rd = 5'd5; WriteData = 32'hDEADBEEF; RdAddr = addrs(5'd0, 5'd0);
        step();
        RegWrite = 1'b0; RdAddr = addrs(5'd5, 5'd5);
        #1;
        chk("rw_both_ports", 64'(RdData), 64'hDEADBEEF_DEADBEEF);
        chk("rw_pend", 64'(RdPend), 64'h0);

        // Zero register ignores writes and is never pending
        RegWrite = 1'b1; Rd = 5'd0; WriteData = 32'h1234; RdAddr = addrs(5'd5, 5'd0);
        #1;
        chk("zero_no_bypass", 64'(RdData[31:0]), 64'h0);
        step();
        RegWrite = 1'b0;
        #1;
        chk("zero_read", 64'(RdData[31:0]), 64'h0);
        Issue = 1'b1; IssueRd = 5'd0;
        #1;
        chk("zero_issue_stall", 64'(Stall), 64'h0);
        step();
        Issue = 1'b0;
        #1;
        chk("zero_not_pending", 64'(RdPend), 64'h0);
        chk("zero_after_stall", 64'(Stall), 64'h0);

        // Bypass on port 1
        RegWrite = 1'b1; Rd = 5'd7; WriteData = 32'hA5A5A5A5; RdAddr = addrs(5'd7, 5'd5);
        #1;
        chk("bypass_data", 64'(RdData), 64'hA5A5A5A5_DEADBEEF);
        chk("bypass_pend1", 64'(RdPend[1]), 64'h0);
        step();
        RegWrite = 1'b0;
        #1;
        chk("bypass_stored", 64'(RdData[63:32]), 64'hA5A5A5A5);

        // RAW then WAW on r3
        Issue = 1'b1; IssueRd = 5'd3; RdAddr = addrs(5'd5, 5'd5);
        #1;
        chk("issue_r3_stall", 64'(Stall), 64'h0);
        step();
        Issue = 1'b0; RdAddr = addrs(5'd5, 5'd3);
        #1;
        chk("raw_pend", 64'(RdPend), 64'h1);
        chk("raw_stall", 64'(Stall), 64'h1);
        RdAddr = addrs(5'd5, 5'd5); Issue = 1'b1; IssueRd = 5'd3;
        #1;
        chk("waw_stall", 64'(Stall), 64'h1);
        // Stalled issue to r4 must not mark r4 pending
        RdAddr = addrs(5'd5, 5'd3); IssueRd = 5'd4;
        #1;
        chk("raw_stall_issue_r4", 64'(Stall), 64'h1);
        step();
        Issue = 1'b0; RdAddr = addrs(5'd4, 5'd3);
        #1;
        chk("stalled_issue_ignored", 64'(RdPend), 64'h1);
        RegWrite = 1'b1; Rd = 5'd3; WriteData = 32'h55;
        #1;
        chk("wb_r3_stall", 64'(Stall), 64'h0);
        chk("wb_r3_bypass", 64'(RdData[31:0]), 64'h55);
        chk("wb_r3_pend", 64'(RdPend), 64'h0);
        Issue = 1'b1; IssueRd = 5'd3;
        #1;
        chk("waw_clearing_no_stall", 64'(Stall), 64'h0);
        Issue = 1'b0;
        step();
        RegWrite = 1'b0;
        #1;
        chk("r3_cleared_pend", 64'(RdPend), 64'h0);
        chk("r3_cleared_stall", 64'(Stall), 64'h0);
        chk("r3_value", 64'(RdData[31:0]), 64'h55);

        // Simultaneous set and clear on r9
        Issue = 1'b1; IssueRd = 5'd9; RdAddr = addrs(5'd5, 5'd5);
        step();
        Issue = 1'b0; RdAddr = addrs(5'd5, 5'd9);
        #1;
        chk("r9_pending", 64'(RdPend), 64'h1);
        RdAddr = addrs(5'd5, 5'd5);
        RegWrite = 1'b1; Rd = 5'd9; WriteData = 32'hCAFEF00D;
        Issue = 1'b1; IssueRd = 5'd9;
        #1;
        chk("set_clear_stall", 64'(Stall), 64'h0);
        step();
        RegWrite = 1'b0; Issue = 1'b0; RdAddr = addrs(5'd5, 5'd9);
        #1;
        chk("set_wins_pend", 64'(RdPend), 64'h1);
        chk("set_clear_data", 64'(RdData[31:0]), 64'hCAFEF00D);
        chk("set_clear_raw", 64'(Stall), 64'h1);

        // Asynchronous reset mid-run
        #1;
        Rst_n = 1'b0;
        #1;
        chk("mid_reset_data", 64'(RdData), 64'h0);
        chk("mid_reset_pend", 64'(RdPend), 64'h0);
        chk("mid_reset_stall", 64'(Stall), 64'h0);
        Rst_n = 1'b1;
        step();
        RdAddr = addrs(5'd7, 5'd3);
        #1;
        chk("post_reset_data", 64'(RdData), 64'h0);
        chk("post_reset_pend", 64'(RdPend), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
